// File: rtl/melody_sequencer.sv
// Note-table player: walks a small note RAM, turns each entry into a half-period
// divider for the square-wave tone stage and gates it with tone_en.
module melody_sequencer #(
  parameter int  NUM_NOTES = 16,
  parameter int  TICK_DIV  = 120000,
  parameter int  GAP_TICKS = 1,
  localparam int ADDR_W    = $clog2(NUM_NOTES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  output logic [14:0]       divider,
  output logic              tone_en,
  output logic              busy,
  output logic [ADDR_W-1:0] note_addr,
  output logic              done
);

  localparam int                PRE_W     = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NOTES - 1);
  localparam logic [7:0]        GAP       = 8'(GAP_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_DONE} state_t;

  state_t              state_reg, state_next;
  logic [15:0]         mem [NUM_NOTES];
  logic [15:0]         rd_data_reg;
  logic [ADDR_W-1:0]   note_addr_reg, note_addr_next;
  logic [14:0]         divider_reg, divider_next;
  logic [7:0]          remaining_reg, remaining_next;
  logic [PRE_W-1:0]    prescaler_reg, prescaler_next;
  logic                rest_reg, rest_next;
  logic                tone_en_reg, busy_reg, done_reg;

  logic                tick;
  logic [7:0]          fetch_dur;
  logic                fetch_rest;
  logic [14:0]         fetch_div;
  logic                unused_bit;

  function automatic logic [14:0] base_div(input logic [3:0] semi);
    case (semi)
      4'd0:    base_div = 15'd22932;
      4'd1:    base_div = 15'd21645;
      4'd2:    base_div = 15'd20430;
      4'd3:    base_div = 15'd19284;
      4'd4:    base_div = 15'd18201;
      4'd5:    base_div = 15'd17180;
      4'd6:    base_div = 15'd16215;
      4'd7:    base_div = 15'd15305;
      4'd8:    base_div = 15'd14446;
      4'd9:    base_div = 15'd13635;
      4'd10:   base_div = 15'd12870;
      4'd11:   base_div = 15'd12148;
      default: base_div = 15'd0;
    endcase
  endfunction

  // Read address follows the next note address so the word is ready during FETCH.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_reg <= mem[note_addr_next];
  end

  assign unused_bit = rd_data_reg[8];
  assign fetch_dur  = rd_data_reg[7:0];
  assign fetch_rest = rd_data_reg[15] | (rd_data_reg[14:13] == 2'b11);
  assign fetch_div  = base_div(rd_data_reg[14:11]) >> rd_data_reg[10:9];
  assign tick       = (prescaler_reg == PRE_LAST);

  always_comb begin
    state_next     = state_reg;
    note_addr_next = note_addr_reg;
    divider_next   = divider_reg;
    remaining_next = remaining_reg;
    prescaler_next = prescaler_reg;
    rest_next      = rest_reg;
    if (stop) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_next     = S_FETCH;
            note_addr_next = '0;
          end
        end
        S_FETCH: begin
          if (fetch_dur == 8'd0) begin
            // An end marker at address 0 must not spin on an empty table.
            if (loop && note_addr_reg != '0) note_addr_next = '0;
            else                             state_next     = S_DONE;
          end else begin
            if (!fetch_rest) divider_next = fetch_div;
            rest_next      = fetch_rest;
            remaining_next = fetch_dur;
            prescaler_next = '0;
            state_next     = S_PLAY;
          end
        end
        S_PLAY: begin
          prescaler_next = tick ? '0 : prescaler_reg + 1'b1;
          if (tick) begin
            if (remaining_reg == 8'd1) begin
              if (note_addr_reg == LAST_ADDR) begin
                if (loop) begin
                  note_addr_next = '0;
                  state_next     = S_FETCH;
                end else begin
                  state_next = S_DONE;
                end
              end else begin
                note_addr_next = note_addr_reg + 1'b1;
                state_next     = S_FETCH;
              end
            end else begin
              remaining_next = remaining_reg - 8'd1;
            end
          end
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      note_addr_reg <= '0;
      divider_reg   <= '0;
      remaining_reg <= '0;
      prescaler_reg <= '0;
      rest_reg      <= 1'b0;
      tone_en_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      note_addr_reg <= note_addr_next;
      divider_reg   <= divider_next;
      remaining_reg <= remaining_next;
      prescaler_reg <= prescaler_next;
      rest_reg      <= rest_next;
      tone_en_reg   <= (state_next == S_PLAY) && !rest_next && (remaining_next > GAP);
      busy_reg      <= (state_next == S_FETCH) || (state_next == S_PLAY);
      done_reg      <= (state_next == S_DONE);
    end
  end

  assign divider   = divider_reg;
  assign tone_en   = tone_en_reg;
  assign busy      = busy_reg;
  assign note_addr = note_addr_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_melody_sequencer.sv
// Randomized scoreboard bench for melody_sequencer: a note-level model predicts
// per-note busy segments and done pulses; a monitor rebuilds them from the outputs.
module tb_melody_sequencer;
  localparam int NUM  = 4;
  localparam int TICK = 4;
  localparam int GAP  = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [14:0] divider;
  logic        tone_en;
  logic        busy;
  logic [1:0]  note_addr;
  logic        done;

  melody_sequencer #(.NUM_NOTES(NUM), .TICK_DIV(TICK), .GAP_TICKS(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .divider(divider), .tone_en(tone_en), .busy(busy),
    .note_addr(note_addr), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int addr;
    int cyc;
    int len;
    int tone;
    int div;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ram_m [NUM];
  int          base_tab [12] = '{22932, 21645, 20430, 19284, 18201, 17180,
                                 16215, 15305, 14446, 13635, 12870, 12148};
  int          mdiv = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  bit in_seg = 1'b0;
  bit prev_done = 1'b0;
  int seg_addr, seg_start, seg_len, seg_tone, seg_div;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [15:0] mk(input bit r, input int semi, input int oct, input int dur);
    return {r, 4'(semi), 2'(oct), 1'b0, 8'(dur)};
  endfunction

  // Note-level model: walks the table, one segment per fetched entry, truncated at a stop.
  task automatic predict(input int c0, input int budget, input bit lp);
    int addr = 0;
    int used = 0;
    while (1) begin
      logic [15:0] w;
      int dur, semi, len, tone, ndiv, seg;
      bit rst;
      exp_t e;
      w    = ram_m[addr];
      dur  = int'(w[7:0]);
      semi = int'(w[14:11]);
      rst  = w[15] || semi >= 12;
      len  = (dur == 0) ? 1 : 1 + dur * TICK;
      tone = (dur == 0 || rst || dur <= GAP) ? 0 : (dur - GAP) * TICK;
      ndiv = (dur == 0 || rst) ? mdiv : (base_tab[semi] >> int'(w[10:9]));
      seg  = (used + len > budget) ? budget - used : len;
      if (tone > seg - 1) tone = seg - 1;
      if (tone < 0) tone = 0;
      e.is_done = 1'b0; e.addr = addr; e.cyc = c0 + used;
      e.len = seg; e.tone = tone; e.div = (seg >= 2) ? ndiv : mdiv;
      exp_q.push_back(e);
      if (seg >= 2) mdiv = ndiv;
      used += seg;
      if (used >= budget) break;
      if (dur != 0 && addr != NUM - 1) begin
        addr++;
      end else if (lp && !(dur == 0 && addr == 0)) begin
        addr = 0;
      end else begin
        e.is_done = 1'b1; e.addr = 0; e.cyc = c0 + used;
        e.len = 0; e.tone = 0; e.div = 0;
        exp_q.push_back(e);
        break;
      end
    end
  endtask

  task automatic close_seg();
    exp_t e;
    in_seg = 1'b0;
    $display("seg addr=%0d start=%0d len=%0d tone=%0d div=%0d",
             seg_addr, seg_start, seg_len, seg_tone, seg_div);
    if (exp_q.size() == 0 || exp_q[0].is_done) begin
      checks++;
      errors++;
      $display("FAIL unexpected_segment actual=addr%0d/len%0d required=none", seg_addr, seg_len);
      return;
    end
    e = exp_q.pop_front();
    chk("seg_addr", seg_addr, e.addr);
    chk("seg_start", seg_start, e.cyc);
    chk("seg_len", seg_len, e.len);
    chk("seg_tone", seg_tone, e.tone);
    chk("seg_div", seg_div, e.div);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_seg = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (in_seg && (!busy || int'(note_addr) != seg_addr)) close_seg();
        if (busy && !in_seg) begin
          in_seg = 1'b1; seg_addr = int'(note_addr); seg_start = cyc;
          seg_len = 0; seg_tone = 0;
        end
        if (busy) begin
          seg_len++;
          if (tone_en) seg_tone++;
          seg_div = int'(divider);
        end else if (tone_en) begin
          checks++;
          errors++;
          $display("FAIL tone_while_idle actual=1 required=0");
        end
        if (done) begin
          $display("done cyc=%0d", cyc);
          if (prev_done) begin
            checks++;
            errors++;
            $display("FAIL done_width actual=2+ required=1");
          end else if (exp_q.size() == 0 || !exp_q[0].is_done) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0");
          end else begin
            e = exp_q.pop_front();
            chk("done_cyc", cyc, e.cyc);
          end
        end
        prev_done = done;
      end
    end
  end

  task automatic write_note(input int a, input logic [15:0] w);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 2'(a); wr_data = w;
    ram_m[a] = w;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_queue", exp_q.size(), 0);
    chk("idle_busy", int'(busy), 0);
    exp_q.delete();
  endtask

  // budget = number of busy cycles before stop takes effect; 0 means no stop.
  task automatic run(input bit lp, input int budget);
    int c0;
    loop = lp;
    @(negedge clk);
    c0 = cyc + 1;
    predict(c0, (budget == 0) ? (1 << 30) : budget, lp);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (budget > 0) begin
      while (cyc < c0 + budget - 1) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
    end
    wait_idle();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_divider"}, int'(divider), 0);
    chk({tag, "_tone_en"}, int'(tone_en), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_note_addr"}, int'(note_addr), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // A4 oct0 dur3, E4 oct1 dur2, end marker
    write_note(0, mk(0, 9, 0, 3));
    write_note(1, mk(0, 4, 1, 2));
    write_note(2, mk(0, 0, 0, 0));
    write_note(3, mk(0, 0, 0, 0));
    run(0, 0);

    // rest entries between notes, semitone 14 treated as rest, full table
    write_note(0, mk(0, 9, 0, 2));
    write_note(1, mk(1, 0, 0, 2));
    write_note(2, mk(0, 14, 0, 1));
    write_note(3, mk(0, 11, 2, 2));
    run(0, 0);

    // two-note loop, then stop
    write_note(0, mk(0, 2, 1, 2));
    write_note(1, mk(0, 7, 3, 1));
    write_note(2, mk(0, 0, 0, 0));
    run(1, 60);

    // full table, no end marker
    write_note(0, mk(0, 0, 0, 1));
    write_note(1, mk(0, 5, 2, 3));
    write_note(2, mk(0, 10, 1, 1));
    write_note(3, mk(0, 1, 3, 2));
    run(0, 0);
    run(1, 70);
    run(0, 1);

    // empty table with loop set must still finish
    write_note(0, mk(0, 0, 0, 0));
    run(1, 0);

    // start and stop together: stop wins
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (4) @(negedge clk);
    chk("startstop_busy", int'(busy), 0);

    // asynchronous reset mid-note
    write_note(0, mk(0, 5, 0, 10));
    mon_en = 1'b0;
    loop = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_tone", int'(tone_en), 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    mdiv = 0;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    mon_en = 1'b1;
    @(negedge clk);
    run(0, 0);

    for (int t = 0; t < 25; t++) begin
      bit lp;
      int b;
      for (int a = 0; a < NUM; a++) begin
        int dur;
        dur = ($urandom_range(0, 9) < 2) ? 0 : int'($urandom_range(1, 4));
        write_note(a, {1'($urandom_range(0, 4) == 0), 4'($urandom_range(0, 15)),
                       2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'(dur)});
      end
      lp = 1'($urandom_range(0, 1));
      if (lp) b = int'($urandom_range(1, 150));
      else    b = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 80)) : 0;
      run(lp, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
